sdhci_dat_xfer_ctrl: RTL and testbench

Per-transfer data-path sequencer for the SDHCI slot. Started by the command path when a data command issues. Tracks blocks and remaining count, and hands buffer ownership between the host register port and the SD DAT-line engine. Drives the Present State transfer and buffer flags, plus Block Count write-back, into the register logic downstream. That logic derives the Transfer Complete, Buffer Read/Write Ready and DAT-inhibit status from them.

---
 rtl/sdhci_dat_pkg.sv | 11 +
 rtl/sdhci_blk_counter.sv | 35 +++
 rtl/sdhci_dat_xfer_ctrl.sv | 119 +++++++++++
 tb/tb_sdhci_dat_xfer_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sdhci_dat_pkg.sv
// sdhci_dat_pkg: shared types for the SDHCI DAT transfer sequencer
package sdhci_dat_pkg;
  localparam int DefBlkCntWidth = 16;
  typedef enum logic [2:0] {IDLE, RD_CARD, RD_HOST, WR_HOST, WR_CARD, CMD12_WAIT} xfer_state_e;
  typedef struct packed {
    logic read;
    logic multi;
    logic bce;
    logic acmd12;
  } xfer_mode_t;
endpackage

// File: rtl/sdhci_blk_counter.sv
// sdhci_blk_counter: remaining-block counter with saturating decrement and infinite mode
module sdhci_blk_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         load_inf_i,
  input  logic         dec_i,
  output logic [W-1:0] dec_val_o,
  output logic         last_o,
  output logic         more_o
);
  logic [W-1:0] r_rem;
  logic         r_inf;
  assign dec_val_o = r_rem == '0 ? '0 : r_rem - W'(1);
  assign last_o    = !r_inf && r_rem == W'(1);
  assign more_o    = r_inf || r_rem != '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rem <= '0;
      r_inf <= 1'b0;
    end else if (clr_i) begin
      r_rem <= '0;
      r_inf <= 1'b0;
    end else if (load_i) begin
      r_rem <= load_val_i;
      r_inf <= load_inf_i;
    end else if (dec_i && !r_inf) begin
      r_rem <= dec_val_o;
    end
  end
endmodule

// File: rtl/sdhci_dat_xfer_ctrl.sv
// sdhci_dat_xfer_ctrl: per-transfer DAT sequencer handing buffer ownership between host port and DAT engine
module sdhci_dat_xfer_ctrl
  import sdhci_dat_pkg::*;
#(
  parameter int BlkCntWidth = DefBlkCntWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   soft_rst_i,
  input  logic                   start_i,
  input  logic                   read_i,
  input  logic                   multi_block_i,
  input  logic                   block_count_enable_i,
  input  logic                   auto_cmd12_enable_i,
  input  logic [BlkCntWidth-1:0] block_count_i,
  input  logic                   dat_block_done_i,
  input  logic                   dat_error_i,
  input  logic                   host_block_done_i,
  input  logic                   auto_cmd12_done_i,
  output logic                   dat_start_o,
  output logic                   auto_cmd12_req_o,
  output logic                   read_transfer_active_o,
  output logic                   write_transfer_active_o,
  output logic                   buffer_read_enable_o,
  output logic                   buffer_write_enable_o,
  output logic                   block_count_de_o,
  output logic [BlkCntWidth-1:0] block_count_d_o,
  output logic                   xfer_error_o
);
  xfer_state_e            r_state, w_state_nxt;
  xfer_mode_t             r_mode, w_mode_in, w_mode_nxt;
  logic                   r_pend, w_pend_nxt, w_accept, w_wb, w_ac, w_load_inf, w_last, w_more, w_dec;
  logic                   w_dat_start, w_req, w_de, w_err;
  logic [BlkCntWidth-1:0] w_load_val, w_dec_val;
  assign w_mode_in  = '{read: read_i, multi: multi_block_i, bce: block_count_enable_i, acmd12: auto_cmd12_enable_i};
  assign w_accept   = r_state == IDLE && start_i && !(multi_block_i && block_count_enable_i && block_count_i == '0);
  assign w_mode_nxt = w_accept ? w_mode_in : r_mode;
  assign w_wb       = r_mode.multi && r_mode.bce;
  assign w_ac       = r_mode.multi && r_mode.acmd12;
  assign w_load_val = !multi_block_i ? BlkCntWidth'(1) : block_count_enable_i ? block_count_i : '0;
  assign w_load_inf = multi_block_i && !block_count_enable_i;
  sdhci_blk_counter #(.W(BlkCntWidth)) u_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (soft_rst_i),
    .load_i     (w_accept),
    .load_val_i (w_load_val),
    .load_inf_i (w_load_inf),
    .dec_i      (w_dec),
    .dec_val_o  (w_dec_val),
    .last_o     (w_last),
    .more_o     (w_more)
  );
  // r_pend tracks an issued Auto CMD12 whose response has not yet arrived
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend && !auto_cmd12_done_i;
    w_dat_start = 1'b0;
    w_req       = 1'b0;
    w_de        = 1'b0;
    w_err       = 1'b0;
    w_dec       = 1'b0;
    if (r_state == IDLE) begin
      w_pend_nxt = 1'b0;
      if (w_accept) begin
        w_state_nxt = read_i ? RD_CARD : WR_HOST;
        w_dat_start = read_i;
      end
    end else if (dat_error_i) begin
      w_state_nxt = IDLE;
      w_pend_nxt  = 1'b0;
      w_err       = 1'b1;
    end else begin
      case (r_state)
        RD_CARD, WR_CARD: if (dat_block_done_i) begin
          w_dec       = 1'b1;
          w_de        = w_wb;
          w_req       = w_ac && w_last;
          w_pend_nxt  = w_req;
          w_state_nxt = r_state == RD_CARD ? RD_HOST : !w_last ? WR_HOST : w_ac ? CMD12_WAIT : IDLE;
        end
        RD_HOST: if (host_block_done_i) begin
          w_dat_start = w_more;
          w_state_nxt = w_more ? RD_CARD : w_pend_nxt ? CMD12_WAIT : IDLE;
        end
        WR_HOST: if (host_block_done_i) begin
          w_dat_start = 1'b1;
          w_state_nxt = WR_CARD;
        end
        CMD12_WAIT: if (auto_cmd12_done_i) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      {r_mode, r_pend, dat_start_o, auto_cmd12_req_o, xfer_error_o, block_count_de_o, block_count_d_o} <= '0;
      {read_transfer_active_o, write_transfer_active_o, buffer_read_enable_o, buffer_write_enable_o} <= '0;
    end else if (soft_rst_i) begin
      r_state <= IDLE;
      {r_mode, r_pend, dat_start_o, auto_cmd12_req_o, xfer_error_o, block_count_de_o, block_count_d_o} <= '0;
      {read_transfer_active_o, write_transfer_active_o, buffer_read_enable_o, buffer_write_enable_o} <= '0;
    end else begin
      r_state                 <= w_state_nxt;
      r_mode                  <= w_mode_nxt;
      r_pend                  <= w_pend_nxt;
      dat_start_o             <= w_dat_start;
      auto_cmd12_req_o        <= w_req;
      xfer_error_o            <= w_err;
      block_count_de_o        <= w_de;
      block_count_d_o         <= w_de ? w_dec_val : block_count_d_o;
      read_transfer_active_o  <= w_state_nxt != IDLE && w_mode_nxt.read;
      write_transfer_active_o <= w_state_nxt != IDLE && !w_mode_nxt.read;
      buffer_read_enable_o    <= w_state_nxt == RD_HOST;
      buffer_write_enable_o   <= w_state_nxt == WR_HOST;
    end
  end
endmodule

// File: tb/tb_sdhci_dat_xfer_ctrl.sv
// tb_sdhci_dat_xfer_ctrl: directed plus random checks of the DAT sequencer against a transaction-level model
module tb_sdhci_dat_xfer_ctrl;
  logic        clk_i = 0, rst_ni = 0, soft_rst_i = 0, start_i = 0, read_i = 0;
  logic        multi_block_i = 0, block_count_enable_i = 0, auto_cmd12_enable_i = 0;
  logic [15:0] block_count_i = '0;
  logic        dat_block_done_i = 0, dat_error_i = 0, host_block_done_i = 0, auto_cmd12_done_i = 0;
  logic        dat_start_o, auto_cmd12_req_o, read_transfer_active_o, write_transfer_active_o;
  logic        buffer_read_enable_o, buffer_write_enable_o, block_count_de_o, xfer_error_o;
  logic [15:0] block_count_d_o;
  int          tests = 0, fails = 0;

  sdhci_dat_xfer_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .soft_rst_i(soft_rst_i), .start_i(start_i), .read_i(read_i),
    .multi_block_i(multi_block_i), .block_count_enable_i(block_count_enable_i),
    .auto_cmd12_enable_i(auto_cmd12_enable_i), .block_count_i(block_count_i),
    .dat_block_done_i(dat_block_done_i), .dat_error_i(dat_error_i),
    .host_block_done_i(host_block_done_i), .auto_cmd12_done_i(auto_cmd12_done_i),
    .dat_start_o(dat_start_o), .auto_cmd12_req_o(auto_cmd12_req_o),
    .read_transfer_active_o(read_transfer_active_o), .write_transfer_active_o(write_transfer_active_o),
    .buffer_read_enable_o(buffer_read_enable_o), .buffer_write_enable_o(buffer_write_enable_o),
    .block_count_de_o(block_count_de_o), .block_count_d_o(block_count_d_o), .xfer_error_o(xfer_error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  // Transaction-level model: who owns the buffer, blocks left (-1 = unbounded), CMD12 bookkeeping
  bit          m_active, m_read, m_host, m_wb, m_ac, m_wait12, m_pend, m_final;
  int          m_left;
  bit          e_start, e_req, e_err, e_de;
  logic [15:0] e_d = '0;

  initial forever begin
    @(posedge clk_i or negedge rst_ni);
    {e_start, e_req, e_err, e_de} = '0;
    if (!rst_ni || soft_rst_i) begin
      {m_active, m_read, m_host, m_wb, m_ac, m_wait12, m_pend} = '0;
      m_left = 0;
      e_d = '0;
    end else if (!m_active) begin
      if (start_i && !(multi_block_i && block_count_enable_i && block_count_i == 0)) begin
        m_active = 1; m_read = read_i; m_host = !read_i; m_wait12 = 0; m_pend = 0;
        m_left = !multi_block_i ? 1 : block_count_enable_i ? int'(block_count_i) : -1;
        m_wb = multi_block_i && block_count_enable_i;
        m_ac = multi_block_i && auto_cmd12_enable_i;
        e_start = read_i;
      end
    end else if (dat_error_i) begin
      m_active = 0; m_wait12 = 0; m_pend = 0; e_err = 1;
    end else if (m_wait12) begin
      if (auto_cmd12_done_i) begin m_active = 0; m_wait12 = 0; m_pend = 0; end
    end else if (!m_host) begin
      if (dat_block_done_i) begin
        if (m_left > 0) m_left--;
        if (m_wb) begin e_de = 1; e_d = 16'(m_left); end
        m_final = m_left == 0;
        if (m_final && m_ac) begin e_req = 1; m_pend = 1; end
        if (m_read || !m_final) m_host = 1;
        else if (m_ac) m_wait12 = 1;
        else m_active = 0;
      end
    end else begin
      if (host_block_done_i) begin
        if (!m_read || m_left != 0) begin m_host = 0; e_start = 1; end
        else if (m_pend && !auto_cmd12_done_i) m_wait12 = 1;
        else m_active = 0;
      end
      if (auto_cmd12_done_i) m_pend = 0;
    end
  end

  initial forever begin
    @(negedge clk_i);
    chk("m_dat_start", dat_start_o, e_start);
    chk("m_cmd12_req", auto_cmd12_req_o, e_req);
    chk("m_xfer_error", xfer_error_o, e_err);
    chk("m_cnt_de", block_count_de_o, e_de);
    chk("m_cnt_d", block_count_d_o, e_d);
    chk("m_rd_active", read_transfer_active_o, m_active && m_read);
    chk("m_wr_active", write_transfer_active_o, m_active && !m_read);
    chk("m_buf_rd_en", buffer_read_enable_o, m_active && m_read && m_host && !m_wait12);
    chk("m_buf_wr_en", buffer_write_enable_o, m_active && !m_read && m_host && !m_wait12);
  end

  task automatic step;
    @(posedge clk_i);
    #1;
    {start_i, dat_block_done_i, dat_error_i, host_block_done_i, auto_cmd12_done_i, soft_rst_i} = '0;
  endtask

  task automatic mode(input logic rd, input logic mb, input logic bce, input logic ac, input logic [15:0] cnt);
    read_i = rd; multi_block_i = mb; block_count_enable_i = bce; auto_cmd12_enable_i = ac; block_count_i = cnt;
    start_i = 1;
  endtask

  initial begin
    #3;
    chk("rst_rd_act", read_transfer_active_o, 0);
    chk("rst_cnt_d", block_count_d_o, 0);
    chk("rst_dat_start", dat_start_o, 0);
    step; step; rst_ni = 1; step;
    // single-block read
    mode(1, 0, 0, 0, 0); step;
    chk("sr_dat_start", dat_start_o, 1);
    chk("sr_rd_act", read_transfer_active_o, 1);
    dat_block_done_i = 1; step;
    chk("sr_buf_rd_en", buffer_read_enable_o, 1);
    chk("sr_no_de", block_count_de_o, 0);
    host_block_done_i = 1; step;
    chk("sr_rd_act_off", read_transfer_active_o, 0);
    chk("sr_buf_rd_off", buffer_read_enable_o, 0);
    // multi-block write, count 3, Auto CMD12
    mode(0, 1, 1, 1, 3); step;
    chk("mw_buf_wr_en", buffer_write_enable_o, 1);
    chk("mw_wr_act", write_transfer_active_o, 1);
    for (int i = 0; i < 3; i++) begin
      host_block_done_i = 1; step;
      chk("mw_dat_start", dat_start_o, 1);
      chk("mw_buf_wr_off", buffer_write_enable_o, 0);
      dat_block_done_i = 1; step;
      chk("mw_de", block_count_de_o, 1);
      chk("mw_cnt_d", block_count_d_o, 16'(2 - i));
      chk("mw_cmd12_req", auto_cmd12_req_o, 16'(i == 2));
    end
    step;
    chk("mw_wait_act", write_transfer_active_o, 1);
    chk("mw_req_once", auto_cmd12_req_o, 0);
    auto_cmd12_done_i = 1; step;
    chk("mw_wr_act_off", write_transfer_active_o, 0);
    // count enabled with zero blocks is ignored
    mode(1, 1, 1, 0, 0); step;
    chk("z_rd_act", read_transfer_active_o, 0);
    chk("z_dat_start", dat_start_o, 0);
    chk("z_cnt_d", block_count_d_o, 0);
    // error during 2nd of 4 read blocks
    mode(1, 1, 1, 1, 4); step;
    dat_block_done_i = 1; step;
    chk("er_cnt_d1", block_count_d_o, 3);
    host_block_done_i = 1; step;
    chk("er_dat_start2", dat_start_o, 1);
    dat_error_i = 1; step;
    chk("er_xfer_error", xfer_error_o, 1);
    chk("er_rd_act", read_transfer_active_o, 0);
    chk("er_no_req", auto_cmd12_req_o, 0);
    chk("er_cnt_d_kept", block_count_d_o, 3);
    step;
    chk("er_pulse_width", xfer_error_o, 0);
    // error beats block done in the same cycle
    mode(1, 0, 0, 0, 0); step;
    dat_error_i = 1; dat_block_done_i = 1; step;
    chk("eb_xfer_error", xfer_error_o, 1);
    chk("eb_buf_rd_en", buffer_read_enable_o, 0);
    chk("eb_no_de", block_count_de_o, 0);
    // soft reset in WR_CARD
    mode(0, 0, 0, 0, 0); step;
    host_block_done_i = 1; step;
    soft_rst_i = 1; step;
    chk("sw_wr_act", write_transfer_active_o, 0);
    chk("sw_cnt_d", block_count_d_o, 0);
    chk("sw_buf_wr_en", buffer_write_enable_o, 0);
    // read count 2, CMD12 response before final host block
    mode(1, 1, 1, 1, 2); step;
    dat_block_done_i = 1; step;
    host_block_done_i = 1; step;
    dat_block_done_i = 1; step;
    chk("rc_cmd12_req", auto_cmd12_req_o, 1);
    chk("rc_cnt_d", block_count_d_o, 0);
    auto_cmd12_done_i = 1; step;
    chk("rc_rd_act_held", read_transfer_active_o, 1);
    chk("rc_buf_rd_en", buffer_read_enable_o, 1);
    host_block_done_i = 1; step;
    chk("rc_rd_act_off", read_transfer_active_o, 0);
    // asynchronous reset mid-transfer
    mode(1, 0, 0, 0, 0); step;
    #2 rst_ni = 0;
    #1 chk("ar_rd_act", read_transfer_active_o, 0);
    step; rst_ni = 1; step;
    for (int k = 0; k < 3000; k++) begin
      rst_ni               = 1;
      start_i              = $urandom_range(0, 5) == 0;
      read_i               = 1'($urandom_range(0, 1));
      multi_block_i        = 1'($urandom_range(0, 1));
      block_count_enable_i = 1'($urandom_range(0, 1));
      auto_cmd12_enable_i  = 1'($urandom_range(0, 1));
      block_count_i        = 16'($urandom_range(0, 4));
      dat_block_done_i     = $urandom_range(0, 2) == 0;
      host_block_done_i    = $urandom_range(0, 2) == 0;
      auto_cmd12_done_i    = $urandom_range(0, 3) == 0;
      dat_error_i          = $urandom_range(0, 39) == 0;
      soft_rst_i           = $urandom_range(0, 99) == 0;
      @(posedge clk_i);
      #1;
      if (k % 700 == 350) begin
        #2 rst_ni = 0;
        #1;
        chk("rnd_ar_rd_act", read_transfer_active_o, 0);
        chk("rnd_ar_wr_act", write_transfer_active_o, 0);
      end
    end
    rst_ni = 1;
    step; step;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
